// File: rtl/vreg_pkg.sv
// Shared definitions for the masked vector register file.
//   - default geometry (NREG_DEF, LANES_DEF, W_DEF)
//   - index-width helper and default index widths (REG_IW, LANE_IW)
//   - clear-sequencer state encoding
package vreg_pkg;

    localparam int NREG_DEF  = 16;
    localparam int LANES_DEF = 5;
    localparam int W_DEF     = 32;

    // Index width for n items; a single item still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    localparam int REG_IW  = idx_width(NREG_DEF);
    localparam int LANE_IW = idx_width(LANES_DEF);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } vreg_state_t;

endpackage

// File: rtl/vreg_clear_seq.sv
// Post-reset clear sequencer for the vector register file.
// Walks clr_idx from 0 to NREG-1, requesting a zero write of one register per
// cycle, then parks in IDLE until the next reset.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset (restarts the sequence)
//   busy    out  high while the sequence is running (state register decode)
//   clr_we  out  zero-write request for register clr_idx
//   clr_idx out  register currently being cleared
module vreg_clear_seq
    import vreg_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    busy,
    output logic                    clr_we,
    output logic [$clog2(NREG)-1:0] clr_idx
);

    localparam int RIW = $clog2(NREG);

    vreg_state_t    state_r;
    vreg_state_t    state_nxt_s;
    logic [RIW-1:0] clr_idx_r;
    logic [RIW-1:0] clr_idx_nxt_s;
    logic           clr_req_s;

    // State and index registers; reset restarts the walk at register 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {RIW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_idx_r <= clr_idx_nxt_s;
        end
    end

    // Next-state logic: one register cleared per cycle, leave after the last.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        clr_req_s     = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_req_s     = 1'b1;
                clr_idx_nxt_s = clr_idx_r + {{(RIW-1){1'b0}}, 1'b1};
                if (clr_idx_r == RIW'(NREG - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_idx_nxt_s = {RIW{1'b0}};
            end
        endcase
    end

    assign busy    = (state_r == ST_CLEAR);
    // No clearing happens on an edge where reset is sampled.
    assign clr_we  = clr_req_s & ~reset;
    assign clr_idx = clr_idx_r;

endmodule

// File: rtl/vreg_file_masked.sv
// Vector register file: NREG registers x LANES elements x W bits.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   va1, va2       read register indices
//   vr1, vr2       combinational read data, lane k at [k*W +: W]; zero while busy
//   we, vd, wmask, wd   lane-masked vector write
//   ee, ed, el, ewd     single-element insert
//   busy           post-reset clear in progress (writes ignored)
//   err            one-cycle pulse after a cycle whose write was dropped
// BYPASS=1 forwards the same-cycle committed write data to the read ports.
module vreg_file_masked
    import vreg_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int W      = W_DEF,
    parameter int BYPASS = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [$clog2(NREG)-1:0]                 va1,
    input  logic [$clog2(NREG)-1:0]                 va2,
    output logic [LANES*W-1:0]                      vr1,
    output logic [LANES*W-1:0]                      vr2,
    input  logic                                    we,
    input  logic [$clog2(NREG)-1:0]                 vd,
    input  logic [LANES-1:0]                        wmask,
    input  logic [LANES*W-1:0]                      wd,
    input  logic                                    ee,
    input  logic [$clog2(NREG)-1:0]                 ed,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] el,
    input  logic [W-1:0]                            ewd,
    output logic                                    busy,
    output logic                                    err
);

    localparam int RIW = $clog2(NREG);
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [W-1:0]       mem_r [NREG][LANES];
    logic               lane_we_s [NREG][LANES];
    logic [W-1:0]       lane_wd_s [NREG][LANES];
    logic               clr_we_s;
    logic [RIW-1:0]     clr_idx_s;
    logic               el_ok_s;
    logic               vec_ok_s;
    logic               elm_ok_s;
    logic               drop_s;
    logic               err_r;
    logic [LANES*W-1:0] rd1_s;
    logic [LANES*W-1:0] rd2_s;

    vreg_clear_seq #(
        .NREG (NREG)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clr_we  (clr_we_s),
        .clr_idx (clr_idx_s)
    );

    // Extra leading bit so the bound check also works when LANES is a power of two.
    assign el_ok_s  = ({1'b0, el} < (LIW + 1)'(LANES));
    assign vec_ok_s = we & ~busy;
    assign elm_ok_s = ee & ~busy & el_ok_s;
    assign drop_s   = ((we | ee) & busy) | (ee & ~el_ok_s);

    // Per-lane write merge: clear, then vector write, then element insert.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < LANES; k++) begin
                lane_we_s[r][k] = 1'b0;
                lane_wd_s[r][k] = {W{1'b0}};
                if (clr_we_s && (clr_idx_s == RIW'(r))) begin
                    lane_we_s[r][k] = 1'b1;
                    lane_wd_s[r][k] = {W{1'b0}};
                end else if (vec_ok_s && (vd == RIW'(r)) && wmask[k]) begin
                    lane_we_s[r][k] = 1'b1;
                    lane_wd_s[r][k] = wd[k*W +: W];
                end else if (elm_ok_s && (ed == RIW'(r)) && (el == LIW'(k))) begin
                    lane_we_s[r][k] = 1'b1;
                    lane_wd_s[r][k] = ewd;
                end else begin
                    lane_we_s[r][k] = 1'b0;
                    lane_wd_s[r][k] = {W{1'b0}};
                end
            end
        end
    end

    // Storage array; contents are initialised by the clear sequencer, not by reset.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_we_s[r][k]) begin
                    mem_r[r][k] <= lane_wd_s[r][k];
                end
            end
        end
    end

    // Read muxes; with bypass the merged per-lane write data overrides storage.
    always_comb begin
        rd1_s = {(LANES*W){1'b0}};
        rd2_s = {(LANES*W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if ((BYPASS != 0) && lane_we_s[va1][k]) begin
                rd1_s[k*W +: W] = lane_wd_s[va1][k];
            end else begin
                rd1_s[k*W +: W] = mem_r[va1][k];
            end
            if ((BYPASS != 0) && lane_we_s[va2][k]) begin
                rd2_s[k*W +: W] = lane_wd_s[va2][k];
            end else begin
                rd2_s[k*W +: W] = mem_r[va2][k];
            end
        end
    end

    assign vr1 = busy ? {(LANES*W){1'b0}} : rd1_s;
    assign vr2 = busy ? {(LANES*W){1'b0}} : rd2_s;

    // Dropped-write flag, one pulse per offending cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= drop_s;
        end
    end

    assign err = err_r;

endmodule
